vector_output_serializer: RTL and testbench
===========================================

Name: vector_output_serializer

Overview:
Downstream consumer of the CPU's vector output port (`out` / `outFlag`). Captures each valid VECTOR_SIZE x OUTPUT_WIDTH result vector into a small FIFO. Serializes each vector lane by lane into a byte stream with a valid/ready handshake, for the image writer or an external link. The CPU cannot be stalled, so vectors that arrive when the FIFO is full are dropped and flagged.

Parameters:
VECTOR_SIZE, 6, number of lanes per output vector
OUTPUT_WIDTH, 8, bits per lane / per output byte
FIFO_DEPTH, 4, vector entries in the input FIFO; power of 2, >= 2
COUNT_WIDTH, 32, width of the optional byte counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
vector_in  in  VECTOR_SIZE*OUTPUT_WIDTH  CPU `out` bus
vector_valid  in  1  CPU `outFlag`; one vector per high cycle
byte_out  out  OUTPUT_WIDTH  current lane being presented
byte_valid  out  1  byte_out is valid
byte_ready  in  1  consumer accepts byte_out this cycle
fifo_full  out  1  FIFO holds FIFO_DEPTH entries (registered count)
overflow  out  1  sticky: a vector was dropped since reset
idle  out  1  FIFO empty and serializer in IDLE

Behaviour:
- Reset values (sync, active-high): byte_valid=0, byte_out=0, fifo_full=0, overflow=0, idle=1.
  - Reset also clears FIFO pointers, count, lane index and FSM state (IDLE).
- Reset mid-transfer: partial vector and FIFO contents are discarded. byte_valid=0 from the cycle after the reset edge.
- Push rule:
  - A push happens at a clock edge where vector_valid=1 and count<FIFO_DEPTH (registered count at the start of the cycle).
  - A pop in the same cycle does not rescue a push when full.
  - If vector_valid=1 and the FIFO is full: the vector is dropped and overflow<=1. overflow stays 1 until reset.
- Simultaneous push and pop when not full: both happen; count unchanged.
- Lane order: most significant lane first.
  - Lane k (k=0..VECTOR_SIZE-1) is vector[(VECTOR_SIZE-k)*OUTPUT_WIDTH-1 -: OUTPUT_WIDTH].
  - This matches the %b dump order.
- FSM states: IDLE, SEND.
  - IDLE: byte_valid=0. If count>0 at the edge: pop the head into the shift register, lane_idx<=0, go to SEND.
  - SEND: byte_valid=1, byte_out=lane[lane_idx]. byte_out and byte_valid stay stable while byte_ready=0 (no retraction).
  - On a SEND handshake (byte_valid & byte_ready) with lane_idx<VECTOR_SIZE-1: lane_idx increments.
  - On a SEND handshake with lane_idx==VECTOR_SIZE-1:
    - if count>0: pop the next vector, lane_idx<=0, stay in SEND (no bubble);
    - else go to IDLE.
- Latency: vector_valid high in cycle N into an idle block gives byte_valid=1 in cycle N+2 with lane 0.
- Throughput: one byte per cycle with byte_ready=1. Vector-to-vector transitions are gapless.
- Capacity: FIFO_DEPTH vectors in the FIFO plus 1 in the shift register.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- fifo_full = (count==FIFO_DEPTH). idle = (count==0 && state==IDLE).

Optional Feature:
- Macro: OUTPUT_BYTE_COUNT_EN.
- Defined: adds output port byte_count (COUNT_WIDTH bits).
  - Reset value 0.
  - Increments on every byte handshake.
  - Wraps from 2^COUNT_WIDTH-1 to 0.
- Undefined: byte_count port and its logic are absent. All other behaviour is identical.

Test Plan:
- Single vector: reset, then vector_in=48'h010203040506 with vector_valid=1 in cycle 0, byte_ready=1 -> byte_valid high cycles 2-7 with bytes 01,02,03,04,05,06; idle=1 from cycle 8.
- Back-to-back: vectors 48'h0A0B0C0D0E0F and 48'h111213141516 in cycles 0 and 1, byte_ready=1 -> 12 consecutive bytes 0A..0F,11..16 in cycles 2-13 with no gap.
- Backpressure: byte_ready toggles 1,0,1,0 -> each byte held stable while byte_ready=0; order unchanged; total 6 handshakes per vector.
- Overflow: byte_ready=0, vector_valid=1 in cycles 0-5 with distinct vectors V0-V5:
  - V0 is moved to the shift register at cycle 1;
  - fifo_full=1 from cycle 5;
  - V5 is dropped and overflow=1 from cycle 6;
  - after byte_ready=1, exactly V0-V4 (30 bytes) are emitted.
- Reset mid-transfer: assert reset after the 3rd byte of a vector -> byte_valid=0 next cycle, idle=1, overflow=0; a new vector afterwards gives a full 6 bytes.
- OUTPUT_BYTE_COUNT_EN defined, COUNT_WIDTH=4: 3 vectors (18 bytes) -> byte_count ends at 2 (wrap).

Source files
------------

// File: rtl/vector_output_serializer.sv
// Buffers CPU output vectors in a small FIFO and streams them out lane by lane (MS lane first).
// Optional byte handshake counter enabled by defining OUTPUT_BYTE_COUNT_EN.
module vector_output_serializer #(
    parameter int unsigned VECTOR_SIZE  = 6,
    parameter int unsigned OUTPUT_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned COUNT_WIDTH  = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] vector_in,
    input  logic                                vector_valid,
    output logic [OUTPUT_WIDTH-1:0]             byte_out,
    output logic                                byte_valid,
    input  logic                                byte_ready,
    output logic                                fifo_full,
    output logic                                overflow,
    output logic                                idle
`ifdef OUTPUT_BYTE_COUNT_EN
   ,output logic [COUNT_WIDTH-1:0]              byte_count
`endif
);

    localparam int unsigned VecW  = VECTOR_SIZE * OUTPUT_WIDTH;
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LaneW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || COUNT_WIDTH < 1)
    begin : g_bad_param
        $error("vector_output_serializer: FIFO_DEPTH must be a power of 2 >= 2");
    end

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e             state_q, state_d;
    logic [VecW-1:0]    mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q, count_d;
    logic [VecW-1:0]    shift_q;
    logic [LaneW-1:0]   lane_q;
    logic               overflow_q;

    logic fifo_nonempty, is_full, push, pop, handshake, last_lane;

    assign fifo_nonempty = (count_q != '0);
    assign is_full       = (count_q == CntW'(FIFO_DEPTH));
    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign push          = vector_valid & ~is_full;
    assign handshake     = byte_valid & byte_ready;
    assign last_lane     = (lane_q == LaneW'(VECTOR_SIZE - 1));
    assign pop           = fifo_nonempty &
                           ((state_q == StIdle) | (handshake & last_lane));
    assign count_d       = count_q + CntW'(push) - CntW'(pop);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (fifo_nonempty) state_d = StSend;
            StSend: if (handshake && last_lane && !fifo_nonempty) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        byte_valid = (state_q == StSend);
        byte_out   = byte_valid ? shift_q[VecW-1 -: OUTPUT_WIDTH] : '0;
        fifo_full  = is_full;
        idle       = ~fifo_nonempty & (state_q == StIdle);
        overflow   = overflow_q;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= vector_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            lane_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_q | (vector_valid & is_full);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
                shift_q  <= mem_q[rd_ptr_q];
                lane_q   <= '0;
            end else if (handshake) begin
                // Next lane moves into the top slot that drives byte_out.
                shift_q <= shift_q << OUTPUT_WIDTH;
                lane_q  <= lane_q + LaneW'(1);
            end
        end
    end

`ifdef OUTPUT_BYTE_COUNT_EN
    logic [COUNT_WIDTH-1:0] byte_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_count_q <= '0;
        end else if (handshake) begin
            byte_count_q <= byte_count_q + COUNT_WIDTH'(1);
        end
    end

    assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_vector_output_serializer.sv
// Self-checking bench for vector_output_serializer: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_vector_output_serializer;

    localparam int VS = 6;
    localparam int OW = 8;
    localparam int FD = 4;
    localparam int CW = 4;
    localparam int VW = VS * OW;

    logic          clock = 1'b0;
    logic          reset;
    logic [VW-1:0] vector_in;
    logic          vector_valid;
    logic [OW-1:0] byte_out;
    logic          byte_valid;
    logic          byte_ready;
    logic          fifo_full;
    logic          overflow;
    logic          idle;
`ifdef OUTPUT_BYTE_COUNT_EN
    logic [CW-1:0] byte_count;
`endif

    vector_output_serializer #(
        .VECTOR_SIZE (VS),
        .OUTPUT_WIDTH(OW),
        .FIFO_DEPTH  (FD),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .vector_in   (vector_in),
        .vector_valid(vector_valid),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .fifo_full   (fifo_full),
        .overflow    (overflow),
        .idle        (idle)
`ifdef OUTPUT_BYTE_COUNT_EN
       ,.byte_count  (byte_count)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: queued vectors, bytes of the vector being sent, sticky flag, byte count.
    logic [VW-1:0] m_fifo[$];
    logic [OW-1:0] m_cur[$];
    bit            m_ovf = 1'b0;
    int unsigned   m_cnt = 0;

    function automatic void model_edge();
        int            n0;
        bit            full0;
        logic [VW-1:0] v;
        if (reset) begin
            m_fifo.delete();
            m_cur.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
            return;
        end
        n0    = m_fifo.size();
        full0 = (n0 == FD);
        if (m_cur.size() != 0 && byte_ready) begin
            void'(m_cur.pop_front());
            m_cnt++;
        end
        if (m_cur.size() == 0 && n0 > 0) begin
            v = m_fifo.pop_front();
            for (int k = 0; k < VS; k++) m_cur.push_back(v[(VS-k)*OW-1 -: OW]);
        end
        if (vector_valid) begin
            if (full0) m_ovf = 1'b1;
            else m_fifo.push_back(vector_in);
        end
    endfunction

    function automatic logic [3:0] exp_flags();
        return {m_cur.size() != 0, m_fifo.size() == FD, m_ovf,
                m_fifo.size() == 0 && m_cur.size() == 0};
    endfunction

    function automatic logic [OW-1:0] exp_byte();
        return (m_cur.size() != 0) ? m_cur[0] : '0;
    endfunction

    function automatic logic [OW-1:0] lane_of(input logic [VW-1:0] v, input int k);
        return OW'(v >> ((VS - 1 - k) * OW));
    endfunction

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; vector_valid = 1'b0; byte_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; vector_valid = 1'b1; byte_ready = 1'b1;
        vector_in = VW'(48'hDEADBEEF1234);
        tick();
        reset = 1'b0; vector_valid = 1'b0;
        @(negedge clock);
        total++;
        if ({byte_valid, byte_out, fifo_full, overflow, idle} !== {1'b0, 8'h00, 3'b001}) begin
            bad++;
            $display("FAIL reset: got v=%b d=%h f=%b o=%b i=%b, want v=0 d=00 f=0 o=0 i=1",
                     byte_valid, byte_out, fifo_full, overflow, idle);
        end
        tick();
    endtask

    task automatic test_single_vector();
        logic [OW-1:0] got[$];
        int  first = -1;
        logic idle8 = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            vector_valid = (c == 0); vector_in = VW'(48'h010203040506); byte_ready = 1'b1;
            @(negedge clock);
            total++;
            if ({byte_valid, fifo_full, overflow, idle} !== exp_flags() ||
                (byte_valid && byte_out !== exp_byte())) begin
                bad++;
                $display("FAIL single c=%0d: got vfoi=%b d=%h, want vfoi=%b d=%h",
                         c, {byte_valid, fifo_full, overflow, idle}, byte_out,
                         exp_flags(), exp_byte());
            end
            if (byte_valid && first < 0) first = c;
            if (byte_valid) got.push_back(byte_out);
            if (c == 8) idle8 = idle;
            tick();
        end
        total++;
        if (first != 2 || got.size() != 6 || idle8 !== 1'b1) begin
            bad++;
            $display("FAIL single_timing: got first=%0d n=%0d idle8=%b, want first=2 n=6 idle8=1",
                     first, got.size(), idle8);
        end
        for (int k = 0; k < got.size(); k++) begin
            total++;
            if (got[k] !== OW'(k + 1)) begin
                bad++;
                $display("FAIL single_byte%0d: got %h want %h", k, got[k], OW'(k + 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] v0, v1;
        int nbytes = 0;
        v0 = VW'(48'h0A0B0C0D0E0F);
        v1 = VW'(48'h111213141516);
        do_reset();
        for (int c = 0; c < 16; c++) begin
            vector_valid = (c < 2); vector_in = (c == 0) ? v0 : v1; byte_ready = 1'b1;
            @(negedge clock);
            total++;
            if ({byte_valid, fifo_full, overflow, idle} !== exp_flags() ||
                (byte_valid && byte_out !== exp_byte())) begin
                bad++;
                $display("FAIL b2b c=%0d: got vfoi=%b d=%h, want vfoi=%b d=%h",
                         c, {byte_valid, fifo_full, overflow, idle}, byte_out,
                         exp_flags(), exp_byte());
            end
            if (c >= 2 && c <= 13) begin
                total++;
                if (byte_valid !== 1'b1 ||
                    byte_out !== lane_of((c < 8) ? v0 : v1, (c - 2) % 6)) begin
                    bad++;
                    $display("FAIL b2b_stream c=%0d: got v=%b d=%h want v=1 d=%h", c,
                             byte_valid, byte_out, lane_of((c < 8) ? v0 : v1, (c - 2) % 6));
                end
            end
            if (byte_valid) nbytes++;
            tick();
        end
        total++;
        if (nbytes != 12) begin
            bad++;
            $display("FAIL b2b_count: got %0d bytes want 12", nbytes);
        end
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] v;
        logic          pv = 1'b0, pr = 1'b0;
        logic [OW-1:0] pb = '0;
        int            hs = 0;
        v = VW'({$urandom(), $urandom()});
        do_reset();
        for (int c = 0; c < 20; c++) begin
            vector_valid = (c == 0); vector_in = v; byte_ready = (c % 2 == 0);
            @(negedge clock);
            total++;
            if ({byte_valid, fifo_full, overflow, idle} !== exp_flags() ||
                (byte_valid && byte_out !== exp_byte())) begin
                bad++;
                $display("FAIL bp c=%0d: got vfoi=%b d=%h, want vfoi=%b d=%h",
                         c, {byte_valid, fifo_full, overflow, idle}, byte_out,
                         exp_flags(), exp_byte());
            end
            if (pv && !pr) begin
                total++;
                if (byte_valid !== 1'b1 || byte_out !== pb) begin
                    bad++;
                    $display("FAIL bp_hold c=%0d: got v=%b d=%h want v=1 d=%h",
                             c, byte_valid, byte_out, pb);
                end
            end
            if (byte_valid && byte_ready) begin
                total++;
                if (byte_out !== lane_of(v, hs)) begin
                    bad++;
                    $display("FAIL bp_order hs=%0d: got %h want %h", hs, byte_out, lane_of(v, hs));
                end
                hs++;
            end
            pv = byte_valid; pr = byte_ready; pb = byte_out;
            tick();
        end
        total++;
        if (hs != 6) begin
            bad++;
            $display("FAIL bp_handshakes: got %0d want 6", hs);
        end
    endtask

    task automatic test_overflow();
        logic [VW-1:0] v[6];
        logic [OW-1:0] got[$];
        for (int i = 0; i < 6; i++) v[i] = VW'({$urandom(), 8'(i)});
        do_reset();
        for (int c = 0; c < 48; c++) begin
            vector_valid = (c < 6); vector_in = v[(c < 6) ? c : 0]; byte_ready = (c >= 8);
            @(negedge clock);
            total++;
            if ({byte_valid, fifo_full, overflow, idle} !== exp_flags() ||
                (byte_valid && byte_out !== exp_byte())) begin
                bad++;
                $display("FAIL ovf c=%0d: got vfoi=%b d=%h, want vfoi=%b d=%h",
                         c, {byte_valid, fifo_full, overflow, idle}, byte_out,
                         exp_flags(), exp_byte());
            end
            if (c == 4 || c == 5 || c == 6) begin
                total++;
                if ({fifo_full, overflow} !== ((c == 4) ? 2'b00 : (c == 5) ? 2'b10 : 2'b11)) begin
                    bad++;
                    $display("FAIL ovf_flags c=%0d: got full=%b ovf=%b", c, fifo_full, overflow);
                end
            end
            if (byte_valid && byte_ready) got.push_back(byte_out);
            tick();
        end
        total++;
        if (got.size() != 30) begin
            bad++;
            $display("FAIL ovf_count: got %0d bytes want 30", got.size());
        end
        for (int i = 0; i < got.size() && i < 30; i++) begin
            total++;
            if (got[i] !== lane_of(v[i / 6], i % 6)) begin
                bad++;
                $display("FAIL ovf_byte%0d: got %h want %h", i, got[i], lane_of(v[i / 6], i % 6));
            end
        end
    endtask

    // Runs straight after test_overflow so the sticky flag is set going in.
    task automatic test_reset_mid();
        logic [VW-1:0] v0, v1;
        logic [OW-1:0] got[$];
        v0 = VW'({$urandom(), $urandom()});
        v1 = VW'({$urandom(), $urandom()});
        for (int c = 0; c < 22; c++) begin
            vector_valid = (c == 0 || c == 7); vector_in = (c == 0) ? v0 : v1;
            byte_ready = 1'b1; reset = (c == 5);
            @(negedge clock);
            total++;
            if ({byte_valid, fifo_full, overflow, idle} !== exp_flags() ||
                (byte_valid && byte_out !== exp_byte())) begin
                bad++;
                $display("FAIL rstmid c=%0d: got vfoi=%b d=%h, want vfoi=%b d=%h",
                         c, {byte_valid, fifo_full, overflow, idle}, byte_out,
                         exp_flags(), exp_byte());
            end
            if (c == 6) begin
                total++;
                if ({byte_valid, idle, overflow} !== 3'b010) begin
                    bad++;
                    $display("FAIL rstmid_after: got v=%b i=%b o=%b want v=0 i=1 o=0",
                             byte_valid, idle, overflow);
                end
            end
            if (c > 6 && byte_valid) got.push_back(byte_out);
            tick();
        end
        reset = 1'b0;
        total++;
        if (got.size() != 6) begin
            bad++;
            $display("FAIL rstmid_count: got %0d bytes want 6", got.size());
        end
        for (int k = 0; k < got.size() && k < 6; k++) begin
            total++;
            if (got[k] !== lane_of(v1, k)) begin
                bad++;
                $display("FAIL rstmid_byte%0d: got %h want %h", k, got[k], lane_of(v1, k));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            reset        = ($urandom_range(0, 199) == 0);
            vector_valid = ($urandom_range(0, 2) == 0);
            vector_in    = VW'({$urandom(), $urandom()});
            byte_ready   = (c < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            @(negedge clock);
            total++;
            if ({byte_valid, fifo_full, overflow, idle} !== exp_flags() ||
                (byte_valid && byte_out !== exp_byte())) begin
                bad++;
                $display("FAIL random c=%0d: got vfoi=%b d=%h, want vfoi=%b d=%h",
                         c, {byte_valid, fifo_full, overflow, idle}, byte_out,
                         exp_flags(), exp_byte());
            end
`ifdef OUTPUT_BYTE_COUNT_EN
            total++;
            if (byte_count !== CW'(m_cnt)) begin
                bad++;
                $display("FAIL random_count c=%0d: got %0d want %0d", c, byte_count, CW'(m_cnt));
            end
`endif
            tick();
        end
        reset = 1'b0;
    endtask

`ifdef OUTPUT_BYTE_COUNT_EN
    task automatic test_byte_count();
        do_reset();
        for (int c = 0; c < 25; c++) begin
            vector_valid = (c < 3); vector_in = VW'({$urandom(), $urandom()}); byte_ready = 1'b1;
            @(negedge clock);
            total++;
            if (byte_count !== CW'(m_cnt)) begin
                bad++;
                $display("FAIL count c=%0d: got %0d want %0d", c, byte_count, CW'(m_cnt));
            end
            tick();
        end
        @(negedge clock);
        total++;
        if (byte_count !== 4'd2) begin
            bad++;
            $display("FAIL count_wrap: got %0d want 2", byte_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; vector_valid = 1'b0; byte_ready = 1'b0; vector_in = '0;
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid();
`ifdef OUTPUT_BYTE_COUNT_EN
        test_byte_count();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
